key_schedule_ctrl: RTL and testbench

Round-key sequencer for the CLM cipher, sitting directly upstream of `key_expansion` and downstream of the key loader. It takes the masked/transformed cipher key and presents round key 0 to the cipher datapath. It then drives `key_expansion` once per round, chaining each round key into the next expansion. Each round key is handed to the datapath over a valid/ready handshake, for rounds 0..NR.

---
 rtl/key_schedule_ctrl.sv | 128 ++++++++++++
 tb/tb_key_schedule_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Round-key sequencer: loads the cipher key, hands each round key to the
// datapath over valid/ready and drives key_expansion once per round,
// feeding every round key back in as the next expansion input.
module key_schedule_ctrl #(
    parameter int unsigned d  = 4,
    parameter int unsigned NR = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [16*(8+d)-1:0]     key_i,
    output logic [16*(8+d)-1:0]     rk_o,
    output logic [3:0]              rk_round_o,
    output logic                    rk_valid_o,
    input  logic                    rk_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [16*(8+d)-1:0]     ke_in_o,
    output logic                    ke_drdy_o,
    output logic                    ke_first_round_o,
    input  logic                    ke_drdy_i,
    input  logic [16*(8+d)-1:0]     ke_out_i
);

    localparam int unsigned EW = 8 + d;
    localparam int unsigned KW = 16 * EW;
    localparam logic [3:0]  LAST_ROUND = 4'(NR);

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    state_t state;

    // key_expansion always expands the key currently held on rk_o
    assign ke_in_o = rk_o;

    // Schedule FSM; every output is updated on the edge that enters its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rk_o             <= KW'(0);
            rk_round_o       <= 4'd0;
            rk_valid_o       <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            ke_drdy_o        <= 1'b0;
            ke_first_round_o <= 1'b0;
        end else begin
            done_o           <= 1'b0;
            ke_drdy_o        <= 1'b0;
            ke_first_round_o <= 1'b0;

            case (state)
                IDLE: begin
                    // abort outranks start while idle
                    if (start && !abort) begin
                        rk_o       <= key_i;
                        rk_round_o <= 4'd0;
                        rk_valid_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (abort) begin
                        rk_valid_o <= 1'b0;
                        busy_o     <= 1'b0;
                        state      <= IDLE;
                    end else if (rk_ready_i) begin
                        rk_valid_o <= 1'b0;
                        if (rk_round_o == LAST_ROUND) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            ke_drdy_o        <= 1'b1;
                            ke_first_round_o <= (rk_round_o == 4'd0);
                            state            <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // the start pulse is already out; an abort must still drain it
                    state <= abort ? DRAIN : WAIT;
                end

                WAIT: begin
                    if (ke_drdy_i) begin
                        if (abort) begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            rk_o       <= ke_out_i;
                            rk_round_o <= rk_round_o + 4'd1;
                            rk_valid_o <= 1'b1;
                            state      <= PRESENT;
                        end
                    end else if (abort) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // let key_expansion finish its round, then drop the result
                    if (ke_drdy_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    rk_valid_o <= 1'b0;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl with a fixed-latency key_expansion stub
// and a scoreboard of expected round keys checked at each handshake.
module tb_key_schedule_ctrl;

    localparam int unsigned D     = 4;
    localparam int unsigned NR    = 10;
    localparam int unsigned EW    = 8 + D;
    localparam int unsigned KW    = 16 * EW;
    localparam int          LIMIT = 800;

    typedef struct packed {
        logic [3:0]    rnd;
        logic [KW-1:0] key;
    } sb_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [KW-1:0] key_i;
    logic [KW-1:0] rk_o;
    logic [3:0]    rk_round_o;
    logic          rk_valid_o;
    logic          rk_ready_i;
    logic          busy_o;
    logic          done_o;
    logic [KW-1:0] ke_in_o;
    logic          ke_drdy_o;
    logic          ke_first_round_o;
    logic          ke_drdy_i;
    logic [KW-1:0] ke_out_i;

    // stub / manual override of the key_expansion response
    int            stub_lat;
    int            stub_cnt;
    logic          stub_drdy;
    logic [KW-1:0] stub_out;
    logic          manual;
    logic          man_drdy;
    logic [KW-1:0] man_out;

    sb_t sb[$];
    int  checks;
    int  passed;
    int  kd_cnt;
    int  fr_cnt;
    int  done_cnt;
    logic exp_issue;

    assign ke_drdy_i = manual ? man_drdy : stub_drdy;
    assign ke_out_i  = manual ? man_out  : stub_out;

    key_schedule_ctrl #(.d(D), .NR(NR)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .key_i            (key_i),
        .rk_o             (rk_o),
        .rk_round_o       (rk_round_o),
        .rk_valid_o       (rk_valid_o),
        .rk_ready_i       (rk_ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .ke_in_o          (ke_in_o),
        .ke_drdy_o        (ke_drdy_o),
        .ke_first_round_o (ke_first_round_o),
        .ke_drdy_i        (ke_drdy_i),
        .ke_out_i         (ke_out_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [KW-1:0] fill(input logic [EW-1:0] e);
        logic [KW-1:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*EW +: EW] = e;
        return v;
    endfunction

    function automatic logic [KW-1:0] inc_all(input logic [KW-1:0] k);
        logic [KW-1:0] v;
        v = k;
        for (int i = 0; i < 16; i++) v[i*EW +: EW] = k[i*EW +: EW] + EW'(1);
        return v;
    endfunction

    // key_expansion stub: answers ke_in_o+1 per element, stub_lat cycles after the pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            stub_cnt  = 0;
            stub_drdy = 1'b0;
        end else begin
            stub_drdy = 1'b0;
            if (stub_cnt != 0) begin
                stub_cnt = stub_cnt - 1;
                if (stub_cnt == 0) begin
                    stub_drdy = 1'b1;
                    stub_out  = inc_all(ke_in_o);
                end
            end else if (ke_drdy_o && !manual) begin
                stub_cnt = stub_lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // per-cycle monitor: sees the outputs and inputs the next rising edge will act on
    task automatic observe();
        sb_t e;
        if (!rst_n) begin
            exp_issue = 1'b0;
        end else begin
            if (exp_issue || ke_drdy_o)
                chk("issue_after_accept", KW'(ke_drdy_o), KW'(exp_issue));
            if (ke_drdy_o) begin
                kd_cnt = kd_cnt + 1;
                chk("first_round_flag", KW'(ke_first_round_o), KW'(rk_round_o == 4'd0));
            end else if (ke_first_round_o) begin
                chk("first_round_alone", KW'(ke_first_round_o), KW'(0));
            end
            if (ke_first_round_o) fr_cnt = fr_cnt + 1;
            if (done_o) begin
                done_cnt = done_cnt + 1;
                chk("done_busy_low", KW'(busy_o), KW'(0));
                chk("done_sb_empty", KW'(sb.size()), KW'(0));
            end
            if (rk_valid_o && rk_ready_i) begin
                chk("sb_underflow", KW'(sb.size() > 0), KW'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rk_round", KW'(rk_round_o), KW'(e.rnd));
                    chk("rk_key", rk_o, e.key);
                end
            end
            exp_issue = rk_valid_o && rk_ready_i && (rk_round_o != 4'(NR)) && !abort;
        end
    endtask

    task automatic tick();
        observe();
        @(negedge clk);
        #1;
    endtask

    task automatic push_sched(input logic [EW-1:0] base, input int upto);
        sb_t e;
        for (int r = 0; r <= upto; r++) begin
            e.rnd = 4'(r);
            e.key = fill(base + EW'(r));
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic [KW-1:0] k);
        key_i = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, KW'(n < LIMIT), KW'(1));
        tick();
    endtask

    task automatic wait_kd(input string tag);
        int n;
        n = 0;
        while (ke_drdy_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_kd_timeout"}, KW'(n < 100), KW'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rk"}, rk_o, KW'(0));
        chk({tag, "_ke_in"}, ke_in_o, KW'(0));
        chk({tag, "_round"}, KW'(rk_round_o), KW'(0));
        chk({tag, "_valid"}, KW'(rk_valid_o), KW'(0));
        chk({tag, "_busy"}, KW'(busy_o), KW'(0));
        chk({tag, "_done"}, KW'(done_o), KW'(0));
        chk({tag, "_ke_drdy"}, KW'(ke_drdy_o), KW'(0));
        chk({tag, "_first"}, KW'(ke_first_round_o), KW'(0));
    endtask

    initial begin
        int kd0;
        int fr0;
        int dn0;
        int n;
        checks     = 0;
        passed     = 0;
        kd_cnt     = 0;
        fr_cnt     = 0;
        done_cnt   = 0;
        exp_issue  = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        key_i      = '0;
        rk_ready_i = 1'b1;
        stub_lat   = 5;
        stub_out   = '0;
        manual     = 1'b0;
        man_drdy   = 1'b0;
        man_out    = '0;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // full schedule, key 0, latency 5, ready held high
        kd0 = kd_cnt; fr0 = fr_cnt; dn0 = done_cnt;
        push_sched(EW'(12'h000), NR);
        do_start(fill(EW'(12'h000)));
        chk("full_valid_after_start", KW'(rk_valid_o), KW'(1));
        chk("full_busy", KW'(busy_o), KW'(1));
        run_to_done("full");
        chk("full_kd_pulses", KW'(kd_cnt - kd0), KW'(NR));
        chk("full_first_pulses", KW'(fr_cnt - fr0), KW'(1));
        chk("full_done_pulses", KW'(done_cnt - dn0), KW'(1));
        chk("full_idle_busy", KW'(busy_o), KW'(0));
        chk("full_idle_done", KW'(done_o), KW'(0));
        chk("full_last_round", KW'(rk_round_o), KW'(NR));

        // backpressure at round 3
        push_sched(EW'(12'h100), NR);
        do_start(fill(EW'(12'h100)));
        n = 0;
        while (!(rk_round_o == 4'd2 && !rk_valid_o) && n < LIMIT) begin tick(); n++; end
        chk("bp_r2_timeout", KW'(n < LIMIT), KW'(1));
        rk_ready_i = 1'b0;
        n = 0;
        while (rk_valid_o !== 1'b1 && n < LIMIT) begin tick(); n++; end
        chk("bp_r3_timeout", KW'(n < LIMIT), KW'(1));
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("bp_hold_rk", rk_o, fill(EW'(12'h103)));
            chk("bp_hold_round", KW'(rk_round_o), KW'(3));
            chk("bp_hold_valid", KW'(rk_valid_o), KW'(1));
            chk("bp_no_issue", KW'(ke_drdy_o), KW'(0));
        end
        rk_ready_i = 1'b1;
        run_to_done("bp");

        // abort in WAIT with a slow expansion, then a fresh schedule
        stub_lat = 20;
        push_sched(EW'(12'h010), 0);
        do_start(fill(EW'(12'h010)));
        wait_kd("abw");
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abw_drain_busy", KW'(busy_o), KW'(1));
        chk("abw_drain_valid", KW'(rk_valid_o), KW'(0));
        n = 0;
        while (ke_drdy_i !== 1'b1 && n < 100) begin tick(); n++; end
        chk("abw_drdy_timeout", KW'(n < 100), KW'(1));
        tick();
        chk("abw_idle_busy", KW'(busy_o), KW'(0));
        chk("abw_idle_valid", KW'(rk_valid_o), KW'(0));
        chk("abw_rk_kept", rk_o, fill(EW'(12'h010)));
        chk("abw_round_kept", KW'(rk_round_o), KW'(0));
        stub_lat = 5;
        push_sched(EW'(12'h5A5), NR);
        do_start(fill(EW'(12'h5A5)));
        chk("restart_rk0", rk_o, fill(EW'(12'h5A5)));
        run_to_done("restart");

        // abort in the same cycle as the expansion result
        manual = 1'b1;
        push_sched(EW'(12'h020), 0);
        do_start(fill(EW'(12'h020)));
        wait_kd("abc");
        tick();
        tick();
        man_drdy = 1'b1;
        man_out  = fill(EW'(12'h777));
        abort    = 1'b1;
        tick();
        man_drdy = 1'b0;
        abort    = 1'b0;
        chk("abc_busy", KW'(busy_o), KW'(0));
        chk("abc_valid", KW'(rk_valid_o), KW'(0));
        chk("abc_round", KW'(rk_round_o), KW'(0));
        chk("abc_rk", rk_o, fill(EW'(12'h020)));
        tick();
        chk("abc_valid_later", KW'(rk_valid_o), KW'(0));
        manual = 1'b0;

        // start during WAIT is ignored; abort+start in IDLE stays idle
        stub_lat = 20;
        push_sched(EW'(12'h030), NR);
        do_start(fill(EW'(12'h030)));
        wait_kd("sw");
        tick();
        key_i = fill(EW'(12'hFFF));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sw_round", KW'(rk_round_o), KW'(0));
        chk("sw_rk", rk_o, fill(EW'(12'h030)));
        chk("sw_busy", KW'(busy_o), KW'(1));
        run_to_done("sw");
        key_i = fill(EW'(12'h444));
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("as_busy", KW'(busy_o), KW'(0));
        chk("as_valid", KW'(rk_valid_o), KW'(0));
        chk("as_rk", rk_o, fill(EW'(12'h03A)));
        chk("as_round", KW'(rk_round_o), KW'(NR));

        // asynchronous reset in WAIT at round 6
        stub_lat = 5;
        push_sched(EW'(12'h200), 6);
        do_start(fill(EW'(12'h200)));
        n = 0;
        while (!(rk_round_o == 4'd6 && rk_valid_o) && n < LIMIT) begin tick(); n++; end
        chk("ar_r6_timeout", KW'(n < LIMIT), KW'(1));
        tick();
        wait_kd("ar");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        chk("async_rst_sb", KW'(sb.size()), KW'(0));
        exp_issue = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        kd0 = kd_cnt; fr0 = fr_cnt; dn0 = done_cnt;
        push_sched(EW'(12'h300), NR);
        do_start(fill(EW'(12'h300)));
        run_to_done("post_rst");
        chk("post_rst_kd_pulses", KW'(kd_cnt - kd0), KW'(NR));
        chk("post_rst_first_pulses", KW'(fr_cnt - fr0), KW'(1));
        chk("post_rst_done_pulses", KW'(done_cnt - dn0), KW'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
